// File: rtl/param_sequence_detector_pkg.sv
// ---------------------------------------------------------------------------
// param_seq_pkg
//   Shared definitions for the programmable sequence detector: the ASCII
//   constants used by the case-folding compare, the controller state type,
//   and a helper that upper-cases one ASCII letter.
// ---------------------------------------------------------------------------
package param_seq_pkg;

    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_LZ = 8'h7A;
    localparam logic [7:0] CASE_BIT = 8'h20;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Lower-case letters differ from their upper-case form only in CASE_BIT,
    // so clearing that bit folds 'a'..'z' onto 'A'..'Z' and leaves all other
    // codes untouched.
    function automatic logic [7:0] foldAscii(input logic [7:0] c);
        if ((c >= ASCII_LA) && (c <= ASCII_LZ)) begin
            return c & ~CASE_BIT;
        end
        return c;
    endfunction

endpackage

// File: rtl/param_sequence_detector_char_cmp.sv
// ---------------------------------------------------------------------------
// char_cmp
//   Single-character equality comparator with optional ASCII case folding.
//   Folding only has meaning for 8-bit characters; for any other width the
//   compare is always exact.
// Ports
//   a, b    : characters to compare
//   nocase  : 1 = treat 'a'..'z' as equal to 'A'..'Z'
//   eq      : 1 when the (possibly folded) characters are equal
// ---------------------------------------------------------------------------
module char_cmp
    import param_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         nocase,
    output logic         eq
);

    if (W == 8) begin : g_fold
        logic [7:0] aFold;
        logic [7:0] bFold;

        // Both operands are folded so the pattern may be stored in either case.
        always_comb begin
            aFold = nocase ? foldAscii(a) : a;
            bFold = nocase ? foldAscii(b) : b;
        end

        assign eq = (aFold == bFold);
    end else begin : g_exact
        assign eq = (a == b) | (nocase & 1'b0);
    end

endmodule

// File: rtl/param_sequence_detector.sv
// ---------------------------------------------------------------------------
// param_sequence_detector
//   Run-time programmable character-sequence detector. A pattern of
//   1..MAX_LEN characters is written through the config port while idle,
//   then the detector is armed and watches a valid-qualified character
//   stream, pulsing eureka one cycle after every completed match and keeping
//   a saturating count of matches since the last arm.
// Ports
//   clk, rst     : rising-edge clock, synchronous active-low reset
//   cfg_we       : write cfg_char into pattern slot cfg_idx (idle only)
//   cfg_idx      : pattern slot, 0 = first character of the pattern
//   cfg_char     : pattern character
//   cfg_len      : pattern length, latched on arm
//   cfg_overlap  : 1 = matches may share characters, latched on arm
//   cfg_nocase   : 1 = ASCII case-insensitive compare, latched on arm
//   arm, disarm  : single-cycle start / stop pulses
//   char_valid   : char_i carries a stream character this cycle
//   char_i       : stream character
//   armed        : detector running
//   cfg_err      : sticky flag, last arm request had an illegal length
//   eureka       : one-cycle match pulse
//   match_count  : matches since last arm, saturating
// ---------------------------------------------------------------------------
module param_sequence_detector
    import param_seq_pkg::*;
#(
    parameter int CHAR_W  = 8,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [$clog2(MAX_LEN)-1:0]   cfg_idx,
    input  logic [CHAR_W-1:0]            cfg_char,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         cfg_nocase,
    input  logic                         arm,
    input  logic                         disarm,
    input  logic                         char_valid,
    input  logic [CHAR_W-1:0]            char_i,
    output logic                         armed,
    output logic                         cfg_err,
    output logic                         eureka,
    output logic [CNT_W-1:0]             match_count
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic               nocase_q;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_d;
    logic [CNT_W-1:0]   matchCnt_q;
    logic [CNT_W-1:0]   matchCnt_d;
    logic               armed_q;
    logic               cfgErr_q;
    logic               eureka_q;

    logic [CHAR_W-1:0]  pat_q [MAX_LEN];
    logic [CHAR_W-1:0]  win_q [MAX_LEN-1];

    logic [CHAR_W-1:0]  cand    [MAX_LEN];
    logic [CHAR_W-1:0]  patChar [MAX_LEN];
    logic [MAX_LEN-1:0] slotEn;
    logic [MAX_LEN-1:0] eq;

    logic armOk;
    logic accept;
    logic fillOk;
    logic allEq;
    logic hit;

    assign armOk  = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
    assign accept = (state_q == RUN) && char_valid && !disarm;

    // Slot i compares the i-th newest character (slot 0 is the arriving
    // character itself) against pattern[len-1-i], so the newest character
    // lines up with the last pattern character. Slots at or beyond len are
    // masked off and their pattern index is never meaningful.
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_slot
        if (i == 0) begin : g_head
            assign cand[i] = char_i;
        end else begin : g_tail
            assign cand[i] = win_q[i-1];
        end

        assign slotEn[i]  = (LEN_W'(i) < len_q);
        assign patChar[i] = pat_q[IDX_W'(len_q - LEN_W'(i + 1))];

        char_cmp #(
            .W(CHAR_W)
        ) u_cmp (
            .a      (cand[i]),
            .b      (patChar[i]),
            .nocase (nocase_q),
            .eq     (eq[i])
        );
    end

    // The arriving character plus fill buffered ones must cover the pattern.
    assign fillOk = ({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len_q};
    assign allEq  = &(eq | ~slotEn);
    assign hit    = fillOk && allEq;

    // Next fill level and match count for an accepted character. A
    // non-overlapping match empties the window so its characters cannot be
    // reused by the following match.
    always_comb begin
        fill_d     = fill_q;
        matchCnt_d = matchCnt_q;
        if (accept) begin
            if (hit && !overlap_q) begin
                fill_d = '0;
            end else if (fill_q < MAX_LEN_L) begin
                fill_d = fill_q + LEN_W'(1);
            end
            if (hit && (matchCnt_q != CNT_MAX)) begin
                matchCnt_d = matchCnt_q + CNT_W'(1);
            end
        end
    end

    // Controller: arming, disarming, and all registered outputs. Disarm takes
    // priority over a character arriving in the same cycle, which is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            cfgErr_q   <= 1'b0;
            eureka_q   <= 1'b0;
            matchCnt_q <= '0;
            fill_q     <= '0;
            len_q      <= LEN_W'(1);
            overlap_q  <= 1'b0;
            nocase_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    eureka_q <= 1'b0;
                    if (arm) begin
                        if (armOk) begin
                            state_q    <= RUN;
                            armed_q    <= 1'b1;
                            cfgErr_q   <= 1'b0;
                            fill_q     <= '0;
                            matchCnt_q <= '0;
                            len_q      <= cfg_len;
                            overlap_q  <= cfg_overlap;
                            nocase_q   <= cfg_nocase;
                        end else begin
                            cfgErr_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (disarm) begin
                        state_q  <= IDLE;
                        armed_q  <= 1'b0;
                        eureka_q <= 1'b0;
                    end else begin
                        eureka_q   <= accept && hit;
                        fill_q     <= fill_d;
                        matchCnt_q <= matchCnt_d;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    armed_q  <= 1'b0;
                    eureka_q <= 1'b0;
                end
            endcase
        end
    end

    // Pattern storage is only writable while idle so a running search always
    // sees a stable pattern. It is not reset, so a reset only requires re-arming.
    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && cfg_we && (32'(cfg_idx) < MAX_LEN)) begin
            pat_q[cfg_idx] <= cfg_char;
        end
    end

    // History of previously accepted characters, newest in slot 0. Validity
    // of the contents is tracked separately by fill_q.
    always_ff @(posedge clk) begin
        if (rst && accept) begin
            win_q[0] <= char_i;
            for (int k = 1; k < MAX_LEN - 1; k++) begin
                win_q[k] <= win_q[k-1];
            end
        end
    end

    assign armed       = armed_q;
    assign cfg_err     = cfgErr_q;
    assign eureka      = eureka_q;
    assign match_count = matchCnt_q;

endmodule

// File: tb/tb_param_sequence_detector.sv
// ---------------------------------------------------------------------------
// tb_param_sequence_detector
//   Drives directed and random traffic into param_sequence_detector. A
//   reference model keeps the list of accepted characters and decides matches
//   by comparing the tail of that list with the pattern; each predicted match
//   is queued with the cycle on which eureka must appear and the count it
//   must show. A monitor pops the queue on every eureka pulse.
// ---------------------------------------------------------------------------
module tb_param_sequence_detector;

    localparam int CHAR_W  = 8;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         cfg_we;
    logic [$clog2(MAX_LEN)-1:0]   cfg_idx;
    logic [CHAR_W-1:0]            cfg_char;
    logic [$clog2(MAX_LEN+1)-1:0] cfg_len;
    logic                         cfg_overlap;
    logic                         cfg_nocase;
    logic                         arm;
    logic                         disarm;
    logic                         char_valid;
    logic [CHAR_W-1:0]            char_i;
    logic                         armed;
    logic                         cfg_err;
    logic                         eureka;
    logic [CNT_W-1:0]             match_count;

    param_sequence_detector #(
        .CHAR_W  (CHAR_W),
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_char    (cfg_char),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_nocase  (cfg_nocase),
        .arm         (arm),
        .disarm      (disarm),
        .char_valid  (char_valid),
        .char_i      (char_i),
        .armed       (armed),
        .cfg_err     (cfg_err),
        .eureka      (eureka),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              we;
        int              idx;
        byte unsigned    wch;
        bit              arm;
        int              len;
        bit              ov;
        bit              nc;
        bit              dis;
        bit              v;
        byte unsigned    ch;
    } stim_t;

    typedef struct {
        int cycle;
        int count;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   pulses = 0;
    exp_t expQ[$];

    // Reference model state
    bit           mArmed = 1'b0;
    bit           mErr   = 1'b0;
    int           mLen   = 1;
    bit           mOv    = 1'b0;
    bit           mNc    = 1'b0;
    int           mCount = 0;
    byte unsigned mPat [MAX_LEN];
    byte unsigned mHist[$];

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic byte unsigned upcase(input byte unsigned c, input bit nc);
        if (nc && c >= "a" && c <= "z") return c - 8'd32;
        return c;
    endfunction

    // A match is simply: the last len accepted characters spell the pattern.
    function automatic bit tailMatches();
        int n;
        n = mHist.size();
        if (n < mLen) return 1'b0;
        for (int k = 0; k < mLen; k++) begin
            if (upcase(mHist[n - mLen + k], mNc) != upcase(mPat[k], mNc)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic modelStep(input stim_t s);
        exp_t e;
        if (!mArmed) begin
            if (s.we && s.idx < MAX_LEN) mPat[s.idx] = s.wch;
            if (s.arm) begin
                if (s.len >= 1 && s.len <= MAX_LEN) begin
                    mArmed = 1'b1;
                    mErr   = 1'b0;
                    mCount = 0;
                    mHist.delete();
                    mLen   = s.len;
                    mOv    = s.ov;
                    mNc    = s.nc;
                end else begin
                    mErr = 1'b1;
                end
            end
        end else if (s.dis) begin
            mArmed = 1'b0;
        end else if (s.v) begin
            mHist.push_back(s.ch);
            if (mHist.size() > MAX_LEN) void'(mHist.pop_front());
            if (tailMatches()) begin
                if (mCount < CNT_SAT) mCount++;
                e.cycle = cyc + 1;
                e.count = mCount;
                expQ.push_back(e);
                if (!mOv) mHist.delete();
            end
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        cfg_we      = s.we;
        cfg_idx     = 3'(s.idx);
        cfg_char    = s.wch;
        cfg_len     = 4'(s.len);
        cfg_overlap = s.ov;
        cfg_nocase  = s.nc;
        arm         = s.arm;
        disarm      = s.dis;
        char_valid  = s.v;
        char_i      = s.ch;
        modelStep(s);
    endtask

    function automatic stim_t idleS();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(idleS());
    endtask

    task automatic writeSlot(input int idx, input byte unsigned c);
        stim_t s = idleS();
        s.we = 1'b1; s.idx = idx; s.wch = c;
        applyStimulus(s);
    endtask

    task automatic loadPattern(input string p);
        for (int k = 0; k < p.len(); k++) writeSlot(k, p[k]);
    endtask

    task automatic armWith(input int len, input bit ov, input bit nc);
        stim_t s = idleS();
        s.arm = 1'b1; s.len = len; s.ov = ov; s.nc = nc;
        applyStimulus(s);
    endtask

    task automatic disarmDet();
        stim_t s = idleS();
        s.dis = 1'b1;
        applyStimulus(s);
        idleCycles(1);
    endtask

    task automatic sendChar(input byte unsigned c);
        stim_t s = idleS();
        s.v = 1'b1; s.ch = c;
        applyStimulus(s);
    endtask

    task automatic streamStr(input string str);
        for (int k = 0; k < str.len(); k++) sendChar(str[k]);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        cfg_we = 1'b0; arm = 1'b0; disarm = 1'b0; char_valid = 1'b0;
        mArmed = 1'b0; mErr = 1'b0; mCount = 0;
        mHist.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drainCheck(input string name);
        idleCycles(2);
        #1;
        checkOutput({name, " pending matches"}, expQ.size(), 0);
        expQ.delete();
    endtask

    // Monitor: every eureka pulse must correspond to the oldest predicted match.
    always @(negedge clk) begin
        exp_t e;
        if (eureka === 1'b1) begin
            pulses++;
            if (expQ.size() == 0) begin
                checkOutput("spurious eureka", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("eureka cycle", cyc, e.cycle);
                checkOutput("count at eureka", match_count, e.count);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        string alph = "ABab";
        stim_t s;
        int    len;

        rst = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_char = '0; cfg_len = '0;
        cfg_overlap = 1'b0; cfg_nocase = 1'b0; arm = 1'b0; disarm = 1'b0;
        char_valid = 1'b0; char_i = '0;

        doReset();
        idleCycles(1);
        checkOutput("reset armed", armed, 0);
        checkOutput("reset cfg_err", cfg_err, 0);
        checkOutput("reset eureka", eureka, 0);
        checkOutput("reset count", match_count, 0);

        $display("[TB] test 1: full-length pattern");
        loadPattern("VIKHYATH");
        armWith(8, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("t1 armed", armed, 1);
        pulses = 0;
        streamStr("VIKVYMVV");
        streamStr("VIKHYATH");
        drainCheck("t1");
        checkOutput("t1 pulses", pulses, 1);
        checkOutput("t1 count", match_count, 1);

        $display("[TB] test 2: overlap modes");
        disarmDet();
        loadPattern("AA");
        armWith(2, 1'b1, 1'b0);
        pulses = 0;
        streamStr("AAAA");
        drainCheck("t2 ov");
        checkOutput("t2 ov pulses", pulses, 3);
        checkOutput("t2 ov count", match_count, 3);
        disarmDet();
        armWith(2, 1'b0, 1'b0);
        pulses = 0;
        streamStr("AAAA");
        drainCheck("t2 nov");
        checkOutput("t2 nov pulses", pulses, 2);
        checkOutput("t2 nov count", match_count, 2);

        $display("[TB] test 3: case folding");
        disarmDet();
        loadPattern("VIKHYATH");
        armWith(8, 1'b0, 1'b1);
        pulses = 0;
        streamStr("vikhyath");
        drainCheck("t3 nocase");
        checkOutput("t3 nocase pulses", pulses, 1);
        disarmDet();
        armWith(8, 1'b0, 1'b0);
        pulses = 0;
        streamStr("vikhyath");
        drainCheck("t3 case");
        checkOutput("t3 case pulses", pulses, 0);

        $display("[TB] test 4: gaps and mid-stream reset");
        disarmDet();
        armWith(8, 1'b0, 1'b0);
        pulses = 0;
        streamStr("VIK");
        idleCycles(3);
        streamStr("HYATH");
        drainCheck("t4 gap");
        checkOutput("t4 gap pulses", pulses, 1);
        streamStr("VIKHY");
        doReset();
        idleCycles(1);
        checkOutput("t4 reset armed", armed, 0);
        armWith(8, 1'b0, 1'b0);
        pulses = 0;
        streamStr("ATH");
        drainCheck("t4 rearm");
        checkOutput("t4 rearm pulses", pulses, 0);
        checkOutput("t4 rearm count", match_count, 0);

        $display("[TB] test 5: illegal arm, frozen pattern, disarm race");
        disarmDet();
        armWith(0, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("t5 len0 cfg_err", cfg_err, 1);
        checkOutput("t5 len0 armed", armed, 0);
        armWith(9, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("t5 len9 cfg_err", cfg_err, 1);
        checkOutput("t5 len9 armed", armed, 0);
        armWith(8, 1'b0, 1'b0);
        idleCycles(1);
        checkOutput("t5 good arm cfg_err", cfg_err, 0);
        checkOutput("t5 good arm armed", armed, 1);
        writeSlot(0, "Z");
        pulses = 0;
        streamStr("VIKHYATH");
        drainCheck("t5 frozen");
        checkOutput("t5 frozen pulses", pulses, 1);
        pulses = 0;
        streamStr("VIKHYAT");
        s = idleS();
        s.v = 1'b1; s.ch = "H"; s.dis = 1'b1;
        applyStimulus(s);
        drainCheck("t5 race");
        checkOutput("t5 race pulses", pulses, 0);
        checkOutput("t5 race armed", armed, 0);

        $display("[TB] test 6: counter saturation");
        loadPattern("A");
        armWith(1, 1'b0, 1'b0);
        pulses = 0;
        for (int k = 0; k < 300; k++) sendChar("A");
        drainCheck("t6");
        checkOutput("t6 pulses", pulses, 300);
        checkOutput("t6 count", match_count, CNT_SAT);

        $display("[TB] random phase");
        for (int r = 0; r < 8; r++) begin
            disarmDet();
            for (int k = 0; k < MAX_LEN; k++) writeSlot(k, alph[$urandom_range(0, 3)]);
            armWith($urandom_range(0, 9), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            idleCycles(1);
            checkOutput("rand arm cfg_err", cfg_err, mErr);
            checkOutput("rand arm armed", armed, mArmed);
            if (!mArmed) begin
                len = $urandom_range(1, 4);
                armWith(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            for (int k = 0; k < 200; k++) begin
                s = idleS();
                s.v  = ($urandom_range(0, 9) < 7);
                s.ch = alph[$urandom_range(0, 3)];
                if ($urandom_range(0, 49) == 0) begin
                    s.arm = 1'b1;
                    s.len = $urandom_range(1, 8);
                end
                if ($urandom_range(0, 79) == 0) s.dis = 1'b1;
                applyStimulus(s);
                if (!mArmed) armWith(mLen, mOv, mNc);
            end
            drainCheck("rand");
            checkOutput("rand count", match_count, mCount);
            checkOutput("rand armed", armed, mArmed);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
